rf_banked: RTL and testbench

//  Parametrised, multi-bank general-purpose register file for the core's execute stage.
//  Two read ports with same-cycle write bypass, one write port, per-register busy scoreboard for in-flight writes.

---
 rtl/rf_banked_pkg.sv | 21 ++
 rtl/rf_banked_clr_seq.sv | 92 +++++++++
 rtl/rf_banked.sv | 166 ++++++++++++++++
 tb/tb_rf_banked.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_banked_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_banked_pkg
//  Description : Shared definitions for the banked register file: default
//                geometry and clear-sequencer state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_banked_pkg;

    // Default geometry
    localparam int c_RW_DEFAULT    = 16;
    localparam int c_REGNO_DEFAULT = 8;
    localparam int c_BANKS_DEFAULT = 2;

    // Clear sequencer state encodings
    localparam logic [1:0] c_CLR_IDLE  = 2'd0;
    localparam logic [1:0] c_CLR_CLEAR = 2'd1;
    localparam logic [1:0] c_CLR_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rf_banked_clr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rf_banked_clr_seq
//  Description : Bank-clear sequencer. On an accepted request it latches the
//                target bank and walks every register index once, one per
//                cycle, then pulses done for a single cycle.
//  Ports       : i_clk, i_rst_n     clock, async active-low reset
//                i_clr_req          start request (accepted only when idle)
//                i_clr_bank         bank to clear, latched on acceptance
//                o_clr_we           clear write strobe (high while clearing)
//                o_clr_idx          register index being cleared this cycle
//                o_clr_bank         latched bank under clear
//                o_clr_busy         sequencer in CLEAR state
//                o_clr_done         one-cycle pulse after last register
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_banked_clr_seq
    import rf_banked_pkg::*;
#(
    parameter int REGNO = c_REGNO_DEFAULT,
    parameter int RL    = $clog2(REGNO),
    parameter int BL    = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr_req,
    input  logic [BL-1:0] i_clr_bank,
    output logic          o_clr_we,
    output logic [RL-1:0] o_clr_idx,
    output logic [BL-1:0] o_clr_bank,
    output logic          o_clr_busy,
    output logic          o_clr_done
);

    localparam logic [RL-1:0] c_LAST = RL'(REGNO - 1);

    logic [1:0]    r_state;
    logic [RL-1:0] r_cnt;
    logic [BL-1:0] r_bank;
    logic          r_busy;
    logic          r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_CLR_IDLE;
            r_cnt   <= '0;
            r_bank  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                c_CLR_IDLE: begin
                    r_done <= 1'b0;
                    if (i_clr_req) begin
                        r_bank  <= i_clr_bank;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_CLR_CLEAR;
                    end
                end
                c_CLR_CLEAR: begin
                    if (r_cnt == c_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_CLR_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_CLR_DONE: begin
                    // Requests arriving here are ignored by design.
                    r_done  <= 1'b0;
                    r_state <= c_CLR_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_CLR_IDLE;
                end
            endcase
        end
    end

    assign o_clr_we   = r_busy;
    assign o_clr_idx  = r_cnt;
    assign o_clr_bank = r_bank;
    assign o_clr_busy = r_busy;
    assign o_clr_done = r_done;

endmodule
`default_nettype wire

// File: rtl/rf_banked.sv
`default_nettype none
// ============================================================================
//  Module      : rf_banked
//  Description : Multi-bank register file with two combinational read ports
//                (same-cycle write bypass), one one-hot write port, a per-
//                register busy scoreboard and a hardware bank-clear engine.
//  Ports       : i_clk, i_rst_n          clock, async active-low reset
//                i_gie, i_ie, i_wbank,   write port (one-hot enable)
//                i_d
//                i_rbank, i_lout_sel,    read bank and indices
//                i_rout_sel
//                o_lout, o_rout          read data (bypassed)
//                o_lbusy, o_rbusy        registered scoreboard bits
//                i_claim, i_claim_bank,  scoreboard claim port
//                i_claim_sel
//                i_clr_req, i_clr_bank   bank-clear request
//                o_clr_busy, o_clr_done  bank-clear status
//                o_wr_drop               external write discarded this cycle
//                dbg_r0                  bank 0 register 0
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_banked
    import rf_banked_pkg::*;
#(
    parameter int RW    = c_RW_DEFAULT,
    parameter int REGNO = c_REGNO_DEFAULT,
    parameter int BANKS = c_BANKS_DEFAULT,
    parameter int RL    = $clog2(REGNO),
    parameter int BL    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_gie,
    input  logic [REGNO-1:0] i_ie,
    input  logic [BL-1:0]    i_wbank,
    input  logic [RW-1:0]    i_d,
    input  logic [BL-1:0]    i_rbank,
    input  logic [RL-1:0]    i_lout_sel,
    input  logic [RL-1:0]    i_rout_sel,
    output logic [RW-1:0]    o_lout,
    output logic [RW-1:0]    o_rout,
    output logic             o_lbusy,
    output logic             o_rbusy,
    input  logic             i_claim,
    input  logic [BL-1:0]    i_claim_bank,
    input  logic [RL-1:0]    i_claim_sel,
    input  logic             i_clr_req,
    input  logic [BL-1:0]    i_clr_bank,
    output logic             o_clr_busy,
    output logic             o_clr_done,
    output logic             o_wr_drop,
    output logic [RW-1:0]    dbg_r0
);

    logic [RW-1:0] r_regs [BANKS][REGNO];
    logic          r_busy [BANKS][REGNO];

    // With a single bank every bank input collapses to bank 0.
    logic [BL-1:0] w_wbank;
    logic [BL-1:0] w_rbank;
    logic [BL-1:0] w_claim_bank;
    logic [BL-1:0] w_clr_bank_req;

    assign w_wbank        = (BANKS > 1) ? i_wbank      : '0;
    assign w_rbank        = (BANKS > 1) ? i_rbank      : '0;
    assign w_claim_bank   = (BANKS > 1) ? i_claim_bank : '0;
    assign w_clr_bank_req = (BANKS > 1) ? i_clr_bank   : '0;

    logic          w_clr_we;
    logic [RL-1:0] w_clr_idx;
    logic [BL-1:0] w_clr_bank;

    rf_banked_clr_seq #(
        .REGNO (REGNO),
        .RL    (RL),
        .BL    (BL)
    ) u_clr_seq (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr_req  (i_clr_req),
        .i_clr_bank (w_clr_bank_req),
        .o_clr_we   (w_clr_we),
        .o_clr_idx  (w_clr_idx),
        .o_clr_bank (w_clr_bank),
        .o_clr_busy (o_clr_busy),
        .o_clr_done (o_clr_done)
    );

    // Encode the one-hot write enable into a register index.
    logic [RL-1:0] w_widx;
    always_comb begin
        w_widx = '0;
        for (int k = 0; k < REGNO; k++) begin
            if (i_ie[k]) w_widx = RL'(k);
        end
    end

    logic w_eff_we;
    logic w_drop;
    logic w_ext_we;

    assign w_eff_we  = i_gie & (|i_ie);
    // The bank under clear is owned by the clear engine until it finishes.
    assign w_drop    = w_eff_we & w_clr_we & (w_wbank == w_clr_bank);
    assign w_ext_we  = w_eff_we & ~w_drop;
    assign o_wr_drop = w_drop;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar r = 0; r < REGNO; r++) begin : g_reg
            logic w_wr_hit;
            logic w_clr_hit;
            logic w_claim_blk;
            logic w_claim_hit;

            assign w_wr_hit    = w_ext_we & (w_wbank == BL'(b)) & (w_widx == RL'(r));
            assign w_clr_hit   = w_clr_we & (w_clr_bank == BL'(b)) & (w_clr_idx == RL'(r));
            // Registers already cleared, or being cleared now, refuse claims.
            assign w_claim_blk = w_clr_we & (w_clr_bank == BL'(b)) & (RL'(r) <= w_clr_idx);
            assign w_claim_hit = i_claim & (w_claim_bank == BL'(b)) &
                                 (i_claim_sel == RL'(r)) & ~w_claim_blk;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_regs[b][r] <= '0;
                    r_busy[b][r] <= 1'b0;
                end else begin
                    if (w_clr_hit) begin
                        r_regs[b][r] <= '0;
                    end else if (w_wr_hit) begin
                        r_regs[b][r] <= i_d;
                    end

                    // Priority: clear > claim > write completion.
                    if (w_clr_hit) begin
                        r_busy[b][r] <= 1'b0;
                    end else if (w_claim_hit) begin
                        r_busy[b][r] <= 1'b1;
                    end else if (w_wr_hit) begin
                        r_busy[b][r] <= 1'b0;
                    end
                end
            end
        end
    end

    logic w_lbyp;
    logic w_rbyp;

    assign w_lbyp  = w_ext_we & (w_wbank == w_rbank) & (w_widx == i_lout_sel);
    assign w_rbyp  = w_ext_we & (w_wbank == w_rbank) & (w_widx == i_rout_sel);

    assign o_lout  = w_lbyp ? i_d : r_regs[w_rbank][i_lout_sel];
    assign o_rout  = w_rbyp ? i_d : r_regs[w_rbank][i_rout_sel];
    assign o_lbusy = r_busy[w_rbank][i_lout_sel];
    assign o_rbusy = r_busy[w_rbank][i_rout_sel];
    assign dbg_r0  = r_regs[0][0];

    // Multi-hot write enables have no defined meaning.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && i_gie) begin
            assert ($onehot0(i_ie));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_banked.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_banked
//  Description : Directed self-checking bench for rf_banked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_banked;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_gie;
    logic [7:0]  i_ie;
    logic [0:0]  i_wbank;
    logic [15:0] i_d;
    logic [0:0]  i_rbank;
    logic [2:0]  i_lout_sel;
    logic [2:0]  i_rout_sel;
    logic [15:0] o_lout;
    logic [15:0] o_rout;
    logic        o_lbusy;
    logic        o_rbusy;
    logic        i_claim;
    logic [0:0]  i_claim_bank;
    logic [2:0]  i_claim_sel;
    logic        i_clr_req;
    logic [0:0]  i_clr_bank;
    logic        o_clr_busy;
    logic        o_clr_done;
    logic        o_wr_drop;
    logic [15:0] dbg_r0;

    int n_checks = 0;
    int n_fail   = 0;

    rf_banked #(
        .RW    (16),
        .REGNO (8),
        .BANKS (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_gie        (i_gie),
        .i_ie         (i_ie),
        .i_wbank      (i_wbank),
        .i_d          (i_d),
        .i_rbank      (i_rbank),
        .i_lout_sel   (i_lout_sel),
        .i_rout_sel   (i_rout_sel),
        .o_lout       (o_lout),
        .o_rout       (o_rout),
        .o_lbusy      (o_lbusy),
        .o_rbusy      (o_rbusy),
        .i_claim      (i_claim),
        .i_claim_bank (i_claim_bank),
        .i_claim_sel  (i_claim_sel),
        .i_clr_req    (i_clr_req),
        .i_clr_bank   (i_clr_bank),
        .o_clr_busy   (o_clr_busy),
        .o_clr_done   (o_clr_done),
        .o_wr_drop    (o_wr_drop),
        .dbg_r0       (dbg_r0)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance to 2 time units past the next rising edge.
    task automatic step();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [0:0] bank, input logic [7:0] ie, input logic [15:0] d);
        i_gie = 1'b1; i_wbank = bank; i_ie = ie; i_d = d;
    endtask

    initial begin
        i_rst_n = 1'b0; i_gie = 1'b0; i_ie = '0; i_wbank = '0; i_d = '0;
        i_rbank = '0; i_lout_sel = '0; i_rout_sel = '0;
        i_claim = 1'b0; i_claim_bank = '0; i_claim_sel = '0;
        i_clr_req = 1'b0; i_clr_bank = '0;
        step(); step();
        i_rst_n = 1'b1;
        #1;
        chk("rst_dbg_r0",   32'(dbg_r0), 32'h0);
        chk("rst_lout",     32'(o_lout), 32'h0);
        chk("rst_clr_busy", 32'(o_clr_busy), 32'h0);
        chk("rst_clr_done", 32'(o_clr_done), 32'h0);
        chk("rst_wr_drop",  32'(o_wr_drop), 32'h0);

        // Async reset mid-cycle
        wr(1'b0, 8'h01, 16'hA5A5);
        i_claim = 1'b1; i_claim_bank = 1'b0; i_claim_sel = 3'd7;
        step();
        i_gie = 1'b0; i_claim = 1'b0;
        i_rbank = 1'b0; i_lout_sel = 3'd7; i_rout_sel = 3'd0;
        #1;
        chk("pre_rst_dbg_r0", 32'(dbg_r0), 32'hA5A5);
        chk("pre_rst_lbusy",  32'(o_lbusy), 32'h1);
        i_rst_n = 1'b0;
        #1;
        chk("async_rst_dbg_r0", 32'(dbg_r0), 32'h0);
        chk("async_rst_lbusy",  32'(o_lbusy), 32'h0);
        chk("async_rst_rout",   32'(o_rout), 32'h0);
        i_rst_n = 1'b1;

        // Bypass
        step();
        i_gie = 1'b0; i_ie = 8'h04; i_d = 16'hBEEF; i_wbank = 1'b0;
        i_rbank = 1'b0; i_lout_sel = 3'd2; i_rout_sel = 3'd2;
        #1;
        chk("byp_off_lout", 32'(o_lout), 32'h0);
        i_gie = 1'b1;
        #1;
        chk("byp_lout", 32'(o_lout), 32'hBEEF);
        chk("byp_rout", 32'(o_rout), 32'hBEEF);
        step();
        i_gie = 1'b0; i_d = 16'h1234;
        #1;
        chk("byp_gie0_lout", 32'(o_lout), 32'hBEEF);
        chk("byp_gie0_rout", 32'(o_rout), 32'hBEEF);

        // Banking
        wr(1'b0, 8'h08, 16'h1111); step();
        wr(1'b1, 8'h08, 16'h2222); step();
        i_gie = 1'b0; i_lout_sel = 3'd3; i_rbank = 1'b0;
        #1;
        chk("bank0_r3", 32'(o_lout), 32'h1111);
        i_rbank = 1'b1;
        #1;
        chk("bank1_r3", 32'(o_lout), 32'h2222);
        wr(1'b1, 8'h08, 16'h3333); i_rbank = 1'b0;
        #1;
        chk("no_xbank_bypass", 32'(o_lout), 32'h1111);
        i_gie = 1'b0;

        // Scoreboard
        i_claim = 1'b1; i_claim_bank = 1'b0; i_claim_sel = 3'd5;
        step();
        i_claim = 1'b0; i_rbank = 1'b0; i_lout_sel = 3'd5; i_rout_sel = 3'd2;
        #1;
        chk("sb_claim_lbusy", 32'(o_lbusy), 32'h1);
        chk("sb_other_rbusy", 32'(o_rbusy), 32'h0);
        wr(1'b0, 8'h20, 16'h5555);
        #1;
        chk("sb_no_write_bypass", 32'(o_lbusy), 32'h1);
        step();
        i_gie = 1'b0;
        #1;
        chk("sb_write_clears", 32'(o_lbusy), 32'h0);
        wr(1'b0, 8'h20, 16'h5556); i_claim = 1'b1;
        step();
        i_gie = 1'b0; i_claim = 1'b0;
        #1;
        chk("sb_claim_wins", 32'(o_lbusy), 32'h1);
        chk("sb_claim_wins_data", 32'(o_lout), 32'h5556);
        i_claim = 1'b1;
        step();
        i_claim = 1'b0;
        #1;
        chk("sb_reclaim", 32'(o_lbusy), 32'h1);

        // Bank clear
        for (int k = 0; k < 8; k++) begin
            wr(1'b1, 8'h01 << k, 16'h1000 + 16'(k));
            step();
        end
        i_gie = 1'b0;
        i_claim = 1'b1; i_claim_bank = 1'b1; i_claim_sel = 3'd1;
        step();
        i_claim = 1'b0; i_rbank = 1'b1; i_lout_sel = 3'd1; i_rout_sel = 3'd7;
        #1;
        chk("clr_pre_busy", 32'(o_lbusy), 32'h1);
        chk("clr_pre_r7", 32'(o_rout), 32'h1007);
        i_clr_req = 1'b1; i_clr_bank = 1'b1;
        step();
        i_clr_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("clr_busy_run", 32'(o_clr_busy), 32'h1);
            chk("clr_done_early", 32'(o_clr_done), 32'h0);
            step();
        end
        #1;
        chk("clr_busy_end", 32'(o_clr_busy), 32'h0);
        chk("clr_done_pulse", 32'(o_clr_done), 32'h1);
        step();
        #1;
        chk("clr_done_once", 32'(o_clr_done), 32'h0);
        i_rbank = 1'b1;
        for (int k = 0; k < 8; k++) begin
            i_lout_sel = 3'(k);
            #1;
            chk("clr_b1_zero", 32'(o_lout), 32'h0);
        end
        i_lout_sel = 3'd1;
        #1;
        chk("clr_b1_busy", 32'(o_lbusy), 32'h0);
        i_rbank = 1'b0; i_lout_sel = 3'd3; i_rout_sel = 3'd2;
        #1;
        chk("clr_b0_r3", 32'(o_lout), 32'h1111);
        chk("clr_b0_r2", 32'(o_rout), 32'hBEEF);

        // Conflicts during clear
        wr(1'b1, 8'h40, 16'h6666); step();
        i_gie = 1'b0;
        i_clr_req = 1'b1; i_clr_bank = 1'b1;
        step();                                   // CLEAR, idx 0
        i_clr_req = 1'b0;
        wr(1'b1, 8'h40, 16'h7777); i_rbank = 1'b1; i_lout_sel = 3'd6;
        #1;
        chk("cf_wr_drop", 32'(o_wr_drop), 32'h1);
        chk("cf_no_bypass", 32'(o_lout), 32'h6666);
        step();                                   // idx 1
        wr(1'b0, 8'h10, 16'h4444); i_rbank = 1'b0; i_lout_sel = 3'd4;
        i_claim = 1'b1; i_claim_bank = 1'b1; i_claim_sel = 3'd0;
        #1;
        chk("cf_other_no_drop", 32'(o_wr_drop), 32'h0);
        chk("cf_other_bypass", 32'(o_lout), 32'h4444);
        step();                                   // idx 2
        i_gie = 1'b0; i_claim_sel = 3'd2;
        i_rbank = 1'b1; i_lout_sel = 3'd6;
        #1;
        chk("cf_dropped_value", 32'(o_lout), 32'h6666);
        step();                                   // idx 3
        i_claim = 1'b0;
        i_lout_sel = 3'd0; i_rout_sel = 3'd2;
        #1;
        chk("cf_claim_cleared", 32'(o_lbusy), 32'h0);
        chk("cf_claim_loses", 32'(o_rbusy), 32'h0);
        chk("cf_busy_mid", 32'(o_clr_busy), 32'h1);
        i_rbank = 1'b0; i_lout_sel = 3'd4;
        #1;
        chk("cf_b0_landed", 32'(o_lout), 32'h4444);
        i_rst_n = 1'b0;
        #1;
        chk("cf_rst_busy", 32'(o_clr_busy), 32'h0);
        chk("cf_rst_b0", 32'(o_lout), 32'h0);
        i_rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            #1;
            chk("cf_no_done", 32'(o_clr_done), 32'h0);
        end
        wr(1'b1, 8'h40, 16'h8888);
        #1;
        chk("cf_post_no_drop", 32'(o_wr_drop), 32'h0);
        i_gie = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
